// File: rtl/tcdm_bank_tas_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_bank_tas_adapter
// Description : TCDM bank front-end adding an atomic test-and-set operation
//               (read old value, then write all ones) on top of a 1-cycle SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_bank_tas_adapter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_MEM_WIDTH = 11,
   parameter int ID_WIDTH       = 20,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,

   input  logic                      mem_req_i,
   output logic                      mem_gnt_o,
   input  logic [ADDR_MEM_WIDTH:0]   mem_add_i,
   input  logic                      mem_wen_i,
   input  logic [DATA_WIDTH-1:0]     mem_data_i,
   input  logic [DATA_WIDTH/8-1:0]   mem_be_i,
   input  logic [ID_WIDTH-1:0]       mem_id_i,

   output logic [DATA_WIDTH-1:0]     mem_r_data_o,
   output logic                      mem_r_valid_o,
   output logic [ID_WIDTH-1:0]       mem_r_id_o,

   output logic                      sram_req_o,
   output logic                      sram_we_o,
   output logic [ADDR_MEM_WIDTH-1:0] sram_add_o,
   output logic [DATA_WIDTH-1:0]     sram_wdata_o,
   output logic [DATA_WIDTH/8-1:0]   sram_be_o,
   input  logic [DATA_WIDTH-1:0]     sram_rdata_i,

   output logic [CNT_WIDTH-1:0]      tas_count_o
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      TAS_WR = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic                      w_tas_flag;
   logic                      w_tas_start;
   logic                      w_grant;
   logic [ADDR_MEM_WIDTH-1:0] r_tas_idx;
   logic [CNT_WIDTH-1:0]      r_tas_count;
   logic                      r_rvalid;
   logic                      r_rd_resp;
   logic [ID_WIDTH-1:0]       r_rid;

   assign w_tas_flag  = mem_add_i[ADDR_MEM_WIDTH];
   // A TAS-flagged write is a plain write; only a flagged read starts the sequence.
   assign w_tas_start = (r_state == IDLE) && mem_req_i && w_tas_flag && mem_wen_i;
   assign w_grant     = mem_gnt_o && mem_req_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The SRAM strobe is gated by rst_ni so an in-flight TAS write dies on reset.
   always_comb begin
      w_state_next = r_state;
      mem_gnt_o    = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_add_o   = mem_add_i[ADDR_MEM_WIDTH-1:0];
      sram_wdata_o = mem_data_i;
      sram_be_o    = mem_be_i;
      case (r_state)
         IDLE: begin
            mem_gnt_o  = mem_req_i;
            sram_req_o = mem_req_i && rst_ni;
            sram_we_o  = ~mem_wen_i;
            if (w_tas_start) begin
               w_state_next = TAS_WR;
            end
         end
         TAS_WR: begin
            sram_req_o   = rst_ni;
            sram_we_o    = 1'b1;
            sram_add_o   = r_tas_idx;
            sram_wdata_o = '1;
            sram_be_o    = '1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      if (clear_i) begin
         w_state_next = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tas_idx <= '0;
      end else if (w_tas_start) begin
         r_tas_idx <= mem_add_i[ADDR_MEM_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tas_count <= '0;
      end else if (clear_i) begin
         r_tas_count <= '0;
      end else if ((r_state == TAS_WR) && (r_tas_count != '1)) begin
         r_tas_count <= r_tas_count + CNT_WIDTH'(1);
      end
   end

   // Response ID register doubles as the latched request ID of a TAS.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid  <= 1'b0;
         r_rd_resp <= 1'b0;
         r_rid     <= '0;
      end else begin
         r_rvalid  <= w_grant;
         r_rd_resp <= w_grant && mem_wen_i;
         if (w_grant) begin
            r_rid <= mem_id_i;
         end
      end
   end

   assign mem_r_valid_o = r_rvalid;
   assign mem_r_id_o    = r_rid;
   assign mem_r_data_o  = r_rd_resp ? sram_rdata_i : '0;
   assign tas_count_o   = r_tas_count;

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_tas_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_bank_tas_adapter
// Description : Directed scoreboard bench for tcdm_bank_tas_adapter with an
//               SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_tas_adapter;

   localparam int DW = 32;
   localparam int AW = 11;
   localparam int IW = 20;
   localparam int CW = 3;

   logic           clk = 1'b0;
   logic           rst_ni;
   logic           clear_i;
   logic           mem_req_i;
   logic           mem_gnt_o;
   logic [AW:0]    mem_add_i;
   logic           mem_wen_i;
   logic [DW-1:0]  mem_data_i;
   logic [DW/8-1:0] mem_be_i;
   logic [IW-1:0]  mem_id_i;
   logic [DW-1:0]  mem_r_data_o;
   logic           mem_r_valid_o;
   logic [IW-1:0]  mem_r_id_o;
   logic           sram_req_o;
   logic           sram_we_o;
   logic [AW-1:0]  sram_add_o;
   logic [DW-1:0]  sram_wdata_o;
   logic [DW/8-1:0] sram_be_o;
   logic [DW-1:0]  sram_rdata_i;
   logic [CW-1:0]  tas_count_o;

   always #5 clk = ~clk;

   tcdm_bank_tas_adapter #(
      .DATA_WIDTH     (DW),
      .ADDR_MEM_WIDTH (AW),
      .ID_WIDTH       (IW),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .mem_req_i     (mem_req_i),
      .mem_gnt_o     (mem_gnt_o),
      .mem_add_i     (mem_add_i),
      .mem_wen_i     (mem_wen_i),
      .mem_data_i    (mem_data_i),
      .mem_be_i      (mem_be_i),
      .mem_id_i      (mem_id_i),
      .mem_r_data_o  (mem_r_data_o),
      .mem_r_valid_o (mem_r_valid_o),
      .mem_r_id_o    (mem_r_id_o),
      .sram_req_o    (sram_req_o),
      .sram_we_o     (sram_we_o),
      .sram_add_o    (sram_add_o),
      .sram_wdata_o  (sram_wdata_o),
      .sram_be_o     (sram_be_o),
      .sram_rdata_i  (sram_rdata_i),
      .tas_count_o   (tas_count_o)
   );

   // SRAM model: read data appears one cycle after the read strobe.
   logic [DW-1:0] sram_mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (sram_req_o) begin
         if (sram_we_o) begin
            for (int b = 0; b < DW/8; b++) begin
               if (sram_be_o[b]) sram_mem[sram_add_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end
         end else begin
            sram_rdata_i <= sram_mem[sram_add_o];
         end
      end
   end

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } resp_t;

   resp_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic req, input logic tas, input int idx, input logic wen,
                        input logic [DW-1:0] data, input logic [IW-1:0] id);
      @(negedge clk);
      mem_req_i  = req;
      mem_add_i  = {tas, AW'(idx)};
      mem_wen_i  = wen;
      mem_data_i = data;
      mem_be_i   = '1;
      mem_id_i   = id;
      #1;
   endtask

   task automatic expect_resp(input logic [IW-1:0] id, input logic [DW-1:0] data);
      exp_q.push_back({id, data});
   endtask

   // Monitor: every presented response must match the oldest expectation.
   always @(negedge clk) begin
      resp_t e;
      if (rst_ni && mem_r_valid_o) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got id 0x%0h data 0x%0h, expected no response",
                     mem_r_id_o, mem_r_data_o);
         end else begin
            e = exp_q.pop_front();
            chk("resp_id", 32'(mem_r_id_o), 32'(e.id));
            chk("resp_data", mem_r_data_o, e.data);
         end
      end
   end

   initial begin
      for (int i = 0; i < (1<<AW); i++) sram_mem[i] = '0;
      sram_rdata_i = '0;
      rst_ni = 1'b0; clear_i = 1'b0; mem_req_i = 1'b0; mem_add_i = '0;
      mem_wen_i = 1'b1; mem_data_i = '0; mem_be_i = '0; mem_id_i = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_r_valid", 32'(mem_r_valid_o), 0);
      chk("rst_r_id", 32'(mem_r_id_o), 0);
      chk("rst_count", 32'(tas_count_o), 0);
      mem_req_i = 1'b1;
      #1;
      chk("rst_gnt_follows_req", 32'(mem_gnt_o), 1);
      chk("rst_sram_req", 32'(sram_req_o), 0);
      @(negedge clk);
      mem_req_i = 1'b0;
      rst_ni = 1'b1;

      // Write then read back
      drive(1, 0, 3, 0, 32'h0000_00A5, 1);
      chk("wr_gnt", 32'(mem_gnt_o), 1);
      chk("wr_sram_we", 32'(sram_we_o), 1);
      expect_resp(1, 32'h0);
      drive(1, 0, 3, 1, 0, 2);
      chk("rd_gnt", 32'(mem_gnt_o), 1);
      expect_resp(2, 32'h0000_00A5);
      drive(0, 0, 0, 1, 0, 0);

      // TAS on index 3
      drive(1, 1, 3, 1, 0, 7);
      chk("tas_gnt", 32'(mem_gnt_o), 1);
      chk("tas_rd_we", 32'(sram_we_o), 0);
      chk("tas_rd_add", 32'(sram_add_o), 3);
      expect_resp(7, 32'h0000_00A5);
      drive(0, 0, 0, 1, 0, 0);
      chk("tas_wr_req", 32'(sram_req_o), 1);
      chk("tas_wr_we", 32'(sram_we_o), 1);
      chk("tas_wr_add", 32'(sram_add_o), 3);
      chk("tas_wr_data", sram_wdata_o, 32'hFFFF_FFFF);
      chk("tas_wr_be", 32'(sram_be_o), 32'hF);
      drive(0, 0, 0, 1, 0, 0);
      chk("tas_count_1", 32'(tas_count_o), 1);
      drive(1, 0, 3, 1, 0, 11);
      expect_resp(11, 32'hFFFF_FFFF);

      // TAS followed by a held read
      drive(1, 1, 5, 1, 0, 8);
      expect_resp(8, 32'h0);
      drive(1, 0, 3, 1, 0, 9);
      chk("held_gnt_low", 32'(mem_gnt_o), 0);
      drive(1, 0, 3, 1, 0, 9);
      chk("held_gnt_high", 32'(mem_gnt_o), 1);
      expect_resp(9, 32'hFFFF_FFFF);
      drive(0, 0, 0, 1, 0, 0);
      chk("tas_count_2", 32'(tas_count_o), 2);

      // TAS-flagged write is a plain write
      drive(1, 1, 6, 0, 32'h0000_1234, 10);
      chk("tasw_gnt", 32'(mem_gnt_o), 1);
      chk("tasw_we", 32'(sram_we_o), 1);
      chk("tasw_add", 32'(sram_add_o), 6);
      expect_resp(10, 32'h0);
      drive(0, 0, 0, 1, 0, 0);
      chk("tasw_no_second", 32'(sram_req_o), 0);
      drive(1, 0, 6, 1, 0, 12);
      chk("tasw_count", 32'(tas_count_o), 2);
      expect_resp(12, 32'h0000_1234);

      // Saturation of the 3-bit counter
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 10 + k, 1, 0, IW'(20 + k));
         expect_resp(IW'(20 + k), 32'h0);
         drive(0, 0, 0, 1, 0, 0);
      end
      drive(0, 0, 0, 1, 0, 0);
      chk("count_max_m1", 32'(tas_count_o), 6);
      for (int k = 0; k < 2; k++) begin
         drive(1, 1, 14 + k, 1, 0, IW'(24 + k));
         expect_resp(IW'(24 + k), 32'h0);
         drive(0, 0, 0, 1, 0, 0);
      end
      drive(0, 0, 0, 1, 0, 0);
      chk("count_saturated", 32'(tas_count_o), 7);

      // Clear during TAS_WR
      drive(1, 1, 16, 1, 0, 30);
      expect_resp(30, 32'h0);
      drive(0, 0, 0, 1, 0, 0);
      clear_i = 1'b1;
      chk("clr_wr_req", 32'(sram_req_o), 1);
      chk("clr_wr_add", 32'(sram_add_o), 16);
      drive(0, 0, 0, 1, 0, 0);
      clear_i = 1'b0;
      chk("clr_count", 32'(tas_count_o), 0);
      chk("clr_mem_written", sram_mem[16], 32'hFFFF_FFFF);

      // One TAS to make the counter non-zero before reset
      drive(1, 1, 17, 1, 0, 31);
      expect_resp(31, 32'h0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      chk("count_pre_rst", 32'(tas_count_o), 1);

      // Reset in TAS_WR
      drive(1, 1, 21, 1, 0, 40);
      expect_resp(40, 32'h0);
      drive(1, 0, 3, 1, 0, 41);
      chk("rst_tas_wr_req", 32'(sram_req_o), 1);
      rst_ni = 1'b0;
      #1;
      chk("rst_abort_req", 32'(sram_req_o), 0);
      chk("rst_abort_valid", 32'(mem_r_valid_o), 0);
      chk("rst_abort_id", 32'(mem_r_id_o), 0);
      chk("rst_abort_count", 32'(tas_count_o), 0);
      chk("rst_abort_gnt", 32'(mem_gnt_o), 1);
      @(negedge clk);
      chk("rst_no_tas_write", sram_mem[21], 32'h0);
      mem_req_i = 1'b0;
      rst_ni = 1'b1;
      drive(1, 0, 3, 1, 0, 41);
      chk("post_rst_gnt", 32'(mem_gnt_o), 1);
      expect_resp(41, 32'hFFFF_FFFF);
      drive(0, 0, 0, 1, 0, 0);

      repeat (4) @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
